st_sequencer: RTL and testbench
===============================

Name: st_sequencer

Overview:
- Hardwired control sequencer for the memory-write path. It executes one `st Ra, C(Rb)` instruction: fetch, effective-address computation, then RAM write of Ra.
- Sits beside the datapath and drives the same control inputs a load sequence uses, in the opposite memory direction.
- Started by a one-cycle `start` pulse. Reports completion with `done`, and reports a non-store opcode with `illegal`.

Parameters:
- OP_ST, 5'b00010, opcode value in ir[31:27] accepted as a store.
- SEL_PC, 5'b10100, BusDataSelect code for PCout.
- SEL_MDR, 5'b10101, BusDataSelect code for MDRout.
- SEL_ZLO, 5'b10011, BusDataSelect code for Zlowout.
- ALU_ADD, 4'b0011, ALU_op code for add.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run one store; sampled only in IDLE.
- ir  in  32  datapath IR contents; fields ra=ir[26:23], rb=ir[22:19].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of sequence.
- illegal  out  1  sticky; set when fetched opcode is not OP_ST.
- incPC, e_MAR, e_MDR, MDR_read, e_IR, e_Y, e_Z  out  1 each  datapath enables.
- Gra, Grb, e_Rout, BAout, imm_sel  out  1 each  register-select and operand controls.
- ram_read, ram_write  out  1 each  RAM strobes.
- ALU_op  out  4  ALU operation.
- BusDataSelect  out  5  bus source; 0-15 selects R0-R15.

Behaviour:
- Reset (clear=0, asynchronous):
  - state=IDLE.
  - Every output is 0, including illegal.
  - Applies immediately, including mid-sequence; a ram_write in progress is dropped the same instant.
- Outputs are a Moore decode of the state register (plus ir fields where stated). No output depends on start.
- Any signal not listed for a state is 0.
- States and outputs:
  - IDLE: no strobes.
    - start=1 → T0, and illegal clears to 0 on the same edge.
    - start=0 → stay.
  - T0: BusDataSelect=SEL_PC, e_MAR=1, incPC=1 → T1.
  - T1: ram_read=1 → T2.
  - T2: MDR_read=1, e_MDR=1 → T3.
  - T3: BusDataSelect=SEL_MDR, e_IR=1 → T4.
  - T4 (IR now valid):
    - If ir[31:27]≠OP_ST → FAULT, with no outputs asserted in this state.
    - Otherwise: Grb=1, BAout=1, e_Rout=1, BusDataSelect={1'b0,rb}, e_Y=1 → T5.
    - BAout forces 0 onto the bus when rb=0.
  - T5: imm_sel=1, ALU_op=ALU_ADD, e_Z=1 → T6.
  - T6: BusDataSelect=SEL_ZLO, e_MAR=1 → T7.
  - T7: Gra=1, e_Rout=1, BusDataSelect={1'b0,ra}, e_MDR=1, MDR_read=0 (MDR loads from bus) → T8.
  - T8: ram_write=1 → T9.
  - T9: ram_write=1 (two-cycle write hold) → DONE.
  - DONE: done=1 for one cycle → IDLE.
  - FAULT: illegal set to 1, done=1 for one cycle → IDLE. No RAM write has occurred.
- Timing:
  - Latency: start sampled at edge k; T0 is active during cycle k+1; done is high during cycle k+11 on the store path, or k+6 on the fault path.
  - busy is high exactly while state≠IDLE.
  - start while busy is ignored. There is no queueing.
- Mutual exclusions: ram_read and ram_write are never both 1, and the MDR/RAM strobes are never high together with e_IR.
- PC increments exactly once per start, including the fault path.
- Effective address = Rb + sign-extended C. The datapath performs the addition; the sequencer only sequences it. Wrap-around is modulo 2^32 in the datapath.
- State encoding is free. Undefined encodings go to IDLE on the next edge.

Test Plan:
1. Reset-state check: hold clear=0 → all outputs 0, busy=0. Release; with no start, nothing changes for 10 cycles.
2. Store with base register: RAM[1]=0x11900063, R2=0x78, R3=0x46, PC=1, start → RAM[0xDB]=0x46, PC=2, done pulses at k+11, illegal=0.
3. Store with rb=0: IR=`st R5, 0x20(R0)`, R0=0x99, R5=0x1234 → BAout forces 0, so RAM[0x20]=0x1234.
4. Illegal opcode: IR word 0x42000078 (opcode 01000) → FAULT; ram_write never asserted; done at k+6; illegal=1 until the next start, which clears it.
5. Mid-sequence reset: pulse clear=0 during T8 → ram_write drops within the same cycle; state=IDLE; no further strobes.
6. Start while busy: pulse start in T2 and again in T6 → ignored; exactly one done; PC incremented once.

Source files
------------

// File: rtl/st_sequencer.sv
// Hardwired control sequencer for one `st Ra, C(Rb)` instruction: fetch, compute Rb + C
// into MAR, latch Ra into MDR, then hold a two-cycle RAM write.
module st_sequencer #(
  parameter logic [4:0] OP_ST   = 5'b00010,
  parameter logic [4:0] SEL_PC  = 5'b10100,
  parameter logic [4:0] SEL_MDR = 5'b10101,
  parameter logic [4:0] SEL_ZLO = 5'b10011,
  parameter logic [3:0] ALU_ADD = 4'b0011
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        incPC,
  output logic        e_MAR,
  output logic        e_MDR,
  output logic        MDR_read,
  output logic        e_IR,
  output logic        e_Y,
  output logic        e_Z,
  output logic        Gra,
  output logic        Grb,
  output logic        e_Rout,
  output logic        BAout,
  output logic        imm_sel,
  output logic        ram_read,
  output logic        ram_write,
  output logic [3:0]  ALU_op,
  output logic [4:0]  BusDataSelect
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_T8, S_T9, S_DONE, S_FAULT
  } state_t;

  state_t state, state_nx;
  logic   illegal_r;
  logic   op_is_st;

  assign op_is_st = (ir[31:27] == OP_ST);
  assign illegal  = illegal_r;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= S_IDLE;
      illegal_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start)
        illegal_r <= 1'b0;
      else if (state == S_T4 && !op_is_st)
        illegal_r <= 1'b1;
    end
  end

  // Moore decode: the state alone (plus IR register fields in T4/T7) sets every strobe
  always_comb begin
    state_nx      = S_IDLE;
    busy          = (state != S_IDLE);
    done          = 1'b0;
    incPC         = 1'b0;
    e_MAR         = 1'b0;
    e_MDR         = 1'b0;
    MDR_read      = 1'b0;
    e_IR          = 1'b0;
    e_Y           = 1'b0;
    e_Z           = 1'b0;
    Gra           = 1'b0;
    Grb           = 1'b0;
    e_Rout        = 1'b0;
    BAout         = 1'b0;
    imm_sel       = 1'b0;
    ram_read      = 1'b0;
    ram_write     = 1'b0;
    ALU_op        = 4'b0000;
    BusDataSelect = 5'b00000;
    case (state)
      S_IDLE: state_nx = start ? S_T0 : S_IDLE;
      S_T0: begin
        BusDataSelect = SEL_PC;
        e_MAR         = 1'b1;
        incPC         = 1'b1;
        state_nx      = S_T1;
      end
      S_T1: begin
        ram_read = 1'b1;
        state_nx = S_T2;
      end
      S_T2: begin
        MDR_read = 1'b1;
        e_MDR    = 1'b1;
        state_nx = S_T3;
      end
      S_T3: begin
        BusDataSelect = SEL_MDR;
        e_IR          = 1'b1;
        state_nx      = S_T4;
      end
      S_T4: begin
        if (!op_is_st) begin
          state_nx = S_FAULT;
        end else begin
          // BAout makes the datapath drive zero instead of R0 when rb = 0
          Grb           = 1'b1;
          BAout         = 1'b1;
          e_Rout        = 1'b1;
          BusDataSelect = {1'b0, ir[22:19]};
          e_Y           = 1'b1;
          state_nx      = S_T5;
        end
      end
      S_T5: begin
        imm_sel  = 1'b1;
        ALU_op   = ALU_ADD;
        e_Z      = 1'b1;
        state_nx = S_T6;
      end
      S_T6: begin
        BusDataSelect = SEL_ZLO;
        e_MAR         = 1'b1;
        state_nx      = S_T7;
      end
      S_T7: begin
        Gra           = 1'b1;
        e_Rout        = 1'b1;
        BusDataSelect = {1'b0, ir[26:23]};
        e_MDR         = 1'b1;
        state_nx      = S_T8;
      end
      S_T8: begin
        ram_write = 1'b1;
        state_nx  = S_T9;
      end
      S_T9: begin
        ram_write = 1'b1;
        state_nx  = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      S_FAULT: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_st_sequencer.sv
// Bench for st_sequencer: a small datapath/RAM model executes the strobes, and every cycle
// of each run is compared against a cycle-indexed timeline derived from the instruction.
module tb_st_sequencer;

  typedef struct packed {
    logic       busy, done, illegal, incPC, e_MAR, e_MDR, MDR_read, e_IR, e_Y, e_Z;
    logic       Gra, Grb, e_Rout, BAout, imm_sel, ram_read, ram_write;
    logic [3:0] alu;
    logic [4:0] sel;
  } ctl_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rb_val;
    logic [31:0] ra_val;
    int          mask;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    bit          exp_ill;
    int          exp_lat;
  } vec_t;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] ir_r;
  logic        busy, done, illegal, incPC, e_MAR, e_MDR, MDR_read, e_IR, e_Y, e_Z;
  logic        Gra, Grb, e_Rout, BAout, imm_sel, ram_read, ram_write;
  logic [3:0]  ALU_op;
  logic [4:0]  BusDataSelect;
  ctl_t        dut_ctl;

  int n_chk  = 0;
  int n_fail = 0;
  bit ill_model = 1'b0;

  always #5 clock = ~clock;

  st_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir_r),
    .busy(busy), .done(done), .illegal(illegal), .incPC(incPC),
    .e_MAR(e_MAR), .e_MDR(e_MDR), .MDR_read(MDR_read), .e_IR(e_IR),
    .e_Y(e_Y), .e_Z(e_Z), .Gra(Gra), .Grb(Grb), .e_Rout(e_Rout),
    .BAout(BAout), .imm_sel(imm_sel), .ram_read(ram_read), .ram_write(ram_write),
    .ALU_op(ALU_op), .BusDataSelect(BusDataSelect)
  );

  assign dut_ctl = {busy, done, illegal, incPC, e_MAR, e_MDR, MDR_read, e_IR, e_Y, e_Z,
                    Gra, Grb, e_Rout, BAout, imm_sel, ram_read, ram_write, ALU_op, BusDataSelect};

  // Datapath environment driven by the sequencer's strobes
  logic [31:0] regs [0:15];
  logic [31:0] ram  [0:1023];
  logic [31:0] pc_r, mar, mdr, ram_q, y_r, z_r, bus, imm;
  logic        tb_we, tb_pc_we;
  logic [9:0]  tb_addr;
  logic [31:0] tb_data, tb_pc;

  assign imm = {{13{ir_r[18]}}, ir_r[18:0]};

  always_comb begin
    if (BusDataSelect < 5'd16)
      bus = (BAout && BusDataSelect == 5'd0) ? 32'd0 : regs[BusDataSelect[3:0]];
    else if (BusDataSelect == 5'd20) bus = pc_r;
    else if (BusDataSelect == 5'd21) bus = mdr;
    else if (BusDataSelect == 5'd19) bus = z_r;
    else bus = 32'd0;
  end

  always @(posedge clock) begin
    if (tb_we) ram[tb_addr] <= tb_data;
    if (tb_pc_we) pc_r <= tb_pc;
    else if (incPC) pc_r <= pc_r + 32'd1;
    if (e_MAR) mar <= bus;
    if (ram_read) ram_q <= ram[mar[9:0]];
    if (e_MDR) mdr <= MDR_read ? ram_q : bus;
    if (e_IR) ir_r <= bus;
    if (e_Y) y_r <= bus;
    if (e_Z) z_r <= (ALU_op == 4'd3) ? y_r + (imm_sel ? imm : bus) : 32'd0;
    if (ram_write) ram[mar[9:0]] <= mdr;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected strobes s cycles after the start edge, read off the instruction word
  function automatic ctl_t ref_ctl(int s, logic [31:0] instr, bit ill_idle);
    ctl_t c;
    bit   fault;
    int   last;
    c     = '0;
    fault = (instr[31:27] != 5'b00010);
    last  = fault ? 6 : 11;
    c.busy = (s >= 1 && s <= last);
    c.done = (s == last);
    if (s == 0) c.illegal = ill_idle;
    else        c.illegal = fault && (s >= 6);
    if (!fault || s <= 4) begin
      case (s)
        1: begin c.sel = 5'd20; c.e_MAR = 1; c.incPC = 1; end
        2: c.ram_read = 1;
        3: begin c.MDR_read = 1; c.e_MDR = 1; end
        4: begin c.sel = 5'd21; c.e_IR = 1; end
        5: begin c.Grb = 1; c.BAout = 1; c.e_Rout = 1; c.sel = {1'b0, instr[22:19]}; c.e_Y = 1; end
        6: begin c.imm_sel = 1; c.alu = 4'd3; c.e_Z = 1; end
        7: begin c.sel = 5'd19; c.e_MAR = 1; end
        8: begin c.Gra = 1; c.e_Rout = 1; c.sel = {1'b0, instr[26:23]}; c.e_MDR = 1; end
        9, 10: c.ram_write = 1;
        default: ;
      endcase
    end
    return c;
  endfunction

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    @(negedge clock);
    tb_addr = a; tb_data = d; tb_we = 1'b1;
    @(negedge clock);
    tb_we = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] p);
    @(negedge clock);
    tb_pc = p; tb_pc_we = 1'b1;
    @(negedge clock);
    tb_pc_we = 1'b0;
  endtask

  task automatic run_one(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rbv,
                         input logic [31:0] rav, input int mask, input logic [31:0] sentinel_addr,
                         input logic [31:0] sentinel, output int done_step, output int writes);
    int last;
    last = (instr[31:27] != 5'b00010) ? 6 : 11;
    regs[instr[22:19]] = rbv;
    regs[instr[26:23]] = rav;
    poke(pc[9:0], instr);
    if (sentinel_addr[9:0] != pc[9:0]) poke(sentinel_addr[9:0], sentinel);
    set_pc(pc);
    @(negedge clock);
    chk("idle_before_start", dut_ctl, ref_ctl(0, instr, ill_model));
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    done_step = 0;
    writes = 0;
    for (int s = 1; s <= last + 2; s++) begin
      chk($sformatf("ctl_step%0d", s), dut_ctl, ref_ctl(s, instr, ill_model));
      if (done && done_step == 0) done_step = s;
      if (ram_write) writes++;
      start = (s < last) ? mask[s] : 1'b0;
      @(posedge clock);
      #1;
    end
    start = 1'b0;
    ill_model = (last == 6);
  endtask

  vec_t vecs[5];

  initial begin
    int          ds, wr;
    logic [31:0] instr, pc, ea, data, rbv, rav;
    int          mask;

    tb_we = 0; tb_pc_we = 0; tb_addr = 0; tb_data = 0; tb_pc = 0;
    start = 0;
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;

    vecs[0] = '{32'h11900063, 32'd1,     32'h78,  32'h46,   0,                 32'hDB,  32'h46,   0, 11};
    vecs[1] = '{32'h12800020, 32'd8,     32'h99,  32'h1234, 0,                 32'h20,  32'h1234, 0, 11};
    vecs[2] = '{32'h42000078, 32'd12,    32'h5,   32'h6,    0,                 32'h0,   32'h0,    1, 6};
    vecs[3] = '{32'h10BFFFFC, 32'd5,     32'h104, 32'hCAFE, 0,                 32'h100, 32'hCAFE, 0, 11};
    vecs[4] = '{32'h11900063, 32'h40,    32'h78,  32'h77,   (1 << 3) | (1 << 7), 32'hDB, 32'h77,   0, 11};

    // Reset state, then ten quiet cycles with no start
    clear = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", dut_ctl, 0);
    @(negedge clock);
    clear = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      chk($sformatf("idle_no_start%0d", i), dut_ctl, 0);
    end

    foreach (vecs[i]) begin
      run_one(vecs[i].instr, vecs[i].pc, vecs[i].rb_val, vecs[i].ra_val, vecs[i].mask,
              vecs[i].exp_addr, ~vecs[i].exp_data, ds, wr);
      chk($sformatf("vec%0d_done_latency", i), ds, vecs[i].exp_lat);
      chk($sformatf("vec%0d_pc", i), pc_r, vecs[i].pc + 1);
      chk($sformatf("vec%0d_illegal", i), illegal, vecs[i].exp_ill);
      chk($sformatf("vec%0d_writes", i), wr, vecs[i].exp_ill ? 0 : 2);
      if (!vecs[i].exp_ill)
        chk($sformatf("vec%0d_ram", i), ram[vecs[i].exp_addr[9:0]], vecs[i].exp_data);
    end

    // Reset during the first write cycle drops ram_write at once
    regs[2] = 32'h78; regs[3] = 32'h46;
    poke(10'd1, 32'h11900063);
    set_pc(32'd1);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    chk("midreset_write_active", ram_write, 1);
    #2;
    clear = 1'b0;
    #1;
    chk("midreset_outputs_drop", dut_ctl, 0);
    @(negedge clock);
    clear = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk($sformatf("midreset_idle%0d", i), dut_ctl, 0);
    end
    ill_model = 1'b0;

    // Randomized runs against the timeline and datapath outcome
    for (int n = 0; n < 30; n++) begin
      instr = $urandom;
      if ($urandom_range(0, 3) != 0) instr[31:27] = 5'b00010;
      rbv = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 2000);
      rav = $urandom;
      regs[instr[22:19]] = rbv;
      regs[instr[26:23]] = rav;
      ea   = ((instr[22:19] == 4'd0) ? 32'd0 : regs[instr[22:19]]) + {{13{instr[18]}}, instr[18:0]};
      data = regs[instr[26:23]];
      pc   = $urandom_range(0, 1023);
      while (pc[9:0] == ea[9:0]) pc = $urandom_range(0, 1023);
      mask = int'($urandom) & 32'h7FE;
      run_one(instr, pc, regs[instr[22:19]], rav, mask, ea, ~data, ds, wr);
      chk($sformatf("rnd%0d_pc", n), pc_r, pc + 1);
      if (instr[31:27] == 5'b00010) begin
        chk($sformatf("rnd%0d_ram", n), ram[ea[9:0]], data);
        chk($sformatf("rnd%0d_writes", n), wr, 2);
      end else begin
        chk($sformatf("rnd%0d_writes", n), wr, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
